// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the iterative divider.
// The master side issues start with operands; the slave side returns
// busy/done and the held results.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider. A 2*WIDTH-bit dividend is divided
// by a WIDTH-bit divisor, one shift/subtract step per clock, 2*WIDTH steps.
// Start/busy/done handshake; results and the divide-by-zero flag are held
// until the next accepted start.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [QW-1:0]   q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic            busy_r;
  logic            done_r;
  logic [QW-1:0]   quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic            dbz_r;

  logic [WIDTH:0]   r_shift_s;
  logic [QW-1:0]    q_shift_s;
  logic [WIDTH-1:0] r_next_s;
  logic [QW-1:0]    q_next_s;
  logic             accept_s;

  // One restoring step: shift the quotient MSB into the widened partial
  // remainder, subtract the divisor when it fits. The stored remainder is
  // always below the divisor, so WIDTH bits suffice between steps.
  always_comb begin
    r_shift_s = {r_r, q_r[QW-1]};
    q_shift_s = {q_r[QW-2:0], 1'b0};
    if (r_shift_s >= {1'b0, d_r}) begin
      r_next_s = WIDTH'(r_shift_s - {1'b0, d_r});
      q_next_s = q_shift_s | {{(QW-1){1'b0}}, 1'b1};
    end else begin
      r_next_s = r_shift_s[WIDTH-1:0];
      q_next_s = q_shift_s;
    end
  end

  // A start is taken whenever the unit is not busy (IDLE or the DONE cycle).
  always_comb begin
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = bus.start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      q_r         <= {QW{1'b0}};
      r_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {QW{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (accept_s) begin
            q_r <= bus.dividend;
            d_r <= bus.divisor;
            r_r <= {WIDTH{1'b0}};
            if (bus.divisor == {WIDTH{1'b0}}) begin
              // Nothing to iterate: publish the fixed divide-by-zero result.
              count_r     <= {CW{1'b0}};
              quotient_r  <= {QW{1'b1}};
              remainder_r <= {WIDTH{1'b0}};
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
              state_r     <= DONE;
            end else begin
              count_r <= CW'(QW);
              busy_r  <= 1'b1;
              state_r <= RUN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          q_r     <= q_next_s;
          r_r     <= r_next_s;
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            quotient_r  <= q_next_s;
            remainder_r <= r_next_s;
            dbz_r       <= 1'b0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.dbz       = dbz_r;

endmodule
